// File: rtl/player_input_tx.sv
// Serial transmitter for one board's debounced player controls: sends SYNC, payload, checksum
// as 8N1 bytes on any input change, on a forced first frame, and as a periodic heartbeat.
module player_input_tx #(
    parameter int unsigned BAUD_DIV  = 217,
    parameter int unsigned HEARTBEAT = 250000,
    parameter int unsigned GAP_BITS  = 1,
    parameter logic [7:0]  SYNC      = 8'hA5
) (
    input  logic       clock_in,
    input  logic       reset_in,
    input  logic       enable,
    input  logic [1:0] player_id,
    input  logic       left,
    input  logic       right,
    input  logic       up,
    input  logic       down,
    input  logic       chop,
    input  logic       carry,
    output logic       tx_out,
    output logic       busy,
    output logic       frame_done
);

    localparam int unsigned BaudW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int unsigned HbW   = (HEARTBEAT > 1) ? $clog2(HEARTBEAT) : 1;
    localparam int unsigned BitW  = (GAP_BITS > 8) ? $clog2(GAP_BITS) : 3;

    localparam logic [BaudW-1:0] BaudLast = BaudW'(BAUD_DIV - 1);
    localparam logic [HbW-1:0]   HbLast   = HbW'(HEARTBEAT - 1);
    localparam logic [BitW-1:0]  GapLast  = BitW'(GAP_BITS - 1);
    localparam logic [BitW-1:0]  DataLast = BitW'(7);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StGap} state_e;

    state_e            state_q, state_d;
    logic [BaudW-1:0]  baud_q, baud_d;
    logic [BitW-1:0]   bit_q, bit_d;
    logic [1:0]        byte_q, byte_d;
    logic [HbW-1:0]    hb_q, hb_d;
    logic [7:0]        sent_q, sent_d;
    logic              force_q, force_d;

    logic [7:0] payload;
    logic [7:0] cur_byte;
    logic       bit_end;
    logic       trigger;

    assign payload = {player_id, carry, chop, down, up, right, left};
    assign bit_end = (baud_q == BaudLast);
    assign trigger = enable && ((payload != sent_q) || force_q || (hb_q == HbLast));
    assign busy    = (state_q != StIdle);

    // sent_q doubles as the frame snapshot and the last transmitted payload.
    always_comb begin
        cur_byte = SYNC;
        unique case (byte_q)
            2'd0:    cur_byte = SYNC;
            2'd1:    cur_byte = sent_q;
            default: cur_byte = SYNC ^ sent_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        baud_d     = bit_end ? '0 : baud_q + 1'b1;
        bit_d      = bit_q;
        byte_d     = byte_q;
        hb_d       = hb_q;
        sent_d     = sent_q;
        force_d    = force_q;
        tx_out     = 1'b1;
        frame_done = 1'b0;

        case (state_q)
            StIdle: begin
                baud_d = '0;
                if (trigger) begin
                    state_d = StStart;
                    sent_d  = payload;
                    force_d = 1'b0;
                    hb_d    = '0;
                    byte_d  = 2'd0;
                    bit_d   = '0;
                end else if (hb_q != HbLast) begin
                    // Keeps counting with enable low so a heartbeat is due when it rises.
                    hb_d = hb_q + 1'b1;
                end
            end
            StStart: begin
                tx_out = 1'b0;
                if (bit_end) begin
                    state_d = StData;
                    bit_d   = '0;
                end
            end
            StData: begin
                tx_out = cur_byte[bit_q[2:0]];
                if (bit_end) begin
                    if (bit_q == DataLast) begin
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            StStop: begin
                if (bit_end) begin
                    if (byte_q == 2'd2) begin
                        state_d = StGap;
                        bit_d   = '0;
                    end else begin
                        state_d = StStart;
                        byte_d  = byte_q + 2'd1;
                    end
                end
            end
            StGap: begin
                if (bit_end) begin
                    if (bit_q == GapLast) begin
                        state_d    = StIdle;
                        frame_done = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= 2'd0;
            hb_q    <= '0;
            sent_q  <= 8'h00;
            force_q <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            hb_q    <= hb_d;
            sent_q  <= sent_d;
            force_q <= force_d;
        end
    end

endmodule

// File: tb/tb_player_input_tx.sv
// Bench for player_input_tx: randomized input changes, a frame-timing reference model that queues
// expected frames, and a line monitor that decodes tx_out and checks it against the queue.
module tb_player_input_tx;

    localparam int unsigned BAUD = 4;
    localparam int unsigned HB   = 200;
    localparam int unsigned GAP  = 1;
    localparam int FRAME_CYC = (30 + GAP) * BAUD;
    localparam int DATA_CYC  = 30 * BAUD;
    localparam int BYTE_CYC  = 10 * BAUD;

    logic       clock_in = 1'b0;
    logic       reset_in = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] player_id = 2'd0;
    logic       left = 1'b0, right = 1'b0, up = 1'b0, down = 1'b0, chop = 1'b0, carry = 1'b0;
    logic       tx_out, busy, frame_done;

    player_input_tx #(
        .BAUD_DIV  (BAUD),
        .HEARTBEAT (HB),
        .GAP_BITS  (GAP),
        .SYNC      (8'hA5)
    ) dut (
        .clock_in   (clock_in),
        .reset_in   (reset_in),
        .enable     (enable),
        .player_id  (player_id),
        .left       (left),
        .right      (right),
        .up         (up),
        .down       (down),
        .chop       (chop),
        .carry      (carry),
        .tx_out     (tx_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clock_in = ~clock_in;

    typedef struct packed {
        int         start;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
    } frame_t;

    frame_t     exp_q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         rx_frames = 0;
    logic [7:0] rx_last_pay = 8'h00;
    logic [7:0] rx_last_chk = 8'h00;
    bit         mon_active = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [7:0] cur_payload();
        return {player_id, carry, chop, down, up, right, left};
    endfunction

    // Expected line level at offset o from the start bit of a frame.
    function automatic logic wave_bit(input frame_t f, input int o);
        int k;
        int r;
        logic [7:0] by;
        if (o >= DATA_CYC) return 1'b1;
        k  = o / BYTE_CYC;
        r  = (o % BYTE_CYC) / BAUD;
        by = (k == 0) ? f.b0 : (k == 1) ? f.b1 : f.b2;
        if (r == 0) return 1'b0;
        if (r == 9) return 1'b1;
        return by[r-1];
    endfunction

    // Reference model: a frame occupies FRAME_CYC cycles after its trigger; triggers only when free.
    initial begin : model
        int         busy_left;
        logic [7:0] last;
        bit         frc;
        int         hb;
        logic [7:0] p;
        frame_t     f;
        busy_left = 0;
        last      = 8'h00;
        frc       = 1'b1;
        hb        = 0;
        forever begin
            @(posedge clock_in);
            cyc++;
            p = cur_payload();
            if (reset_in) begin
                busy_left = 0;
                last      = 8'h00;
                frc       = 1'b1;
                hb        = 0;
                exp_q.delete();
            end else if (busy_left > 0) begin
                busy_left--;
            end else if (enable && (p != last || frc || hb == HB - 1)) begin
                f.start = cyc;
                f.b0    = 8'hA5;
                f.b1    = p;
                f.b2    = 8'hA5 ^ p;
                exp_q.push_back(f);
                last      = p;
                frc       = 1'b0;
                hb        = 0;
                busy_left = FRAME_CYC;
            end else if (hb < HB - 1) begin
                hb++;
            end
        end
    end

    initial begin : monitor
        bit         rst_seen;
        bit         aborted;
        bit         hit;
        int         r;
        frame_t     f;
        logic [7:0] rx [3];
        rst_seen = 1'b0;
        forever begin
            @(negedge clock_in);
            if (rst_seen) begin
                check("reset_tx", tx_out, 1'b1);
                check("reset_busy", busy, 1'b0);
                check("reset_done", frame_done, 1'b0);
                rst_seen = reset_in;
            end else if (tx_out === 1'b0) begin
                mon_active = 1'b1;
                hit = (exp_q.size() > 0);
                check("frame_expected", hit, 1'b1);
                if (!hit) begin
                    repeat (FRAME_CYC - 1) @(negedge clock_in);
                end else begin
                    f = exp_q.pop_front();
                    check("start_cycle", cyc, f.start);
                    aborted = 1'b0;
                    for (int i = 0; i < 3; i++) rx[i] = 8'h00;
                    for (int o = 0; o < FRAME_CYC; o++) begin
                        if (o > 0) @(negedge clock_in);
                        if (rst_seen) begin
                            check("reset_tx", tx_out, 1'b1);
                            check("reset_busy", busy, 1'b0);
                            aborted  = 1'b1;
                            rst_seen = reset_in;
                            break;
                        end
                        check("tx_bit", tx_out, wave_bit(f, o));
                        check("busy_in_frame", busy, 1'b1);
                        check("frame_done", frame_done, o == FRAME_CYC - 1);
                        r = (o % BYTE_CYC) / BAUD;
                        if (o < DATA_CYC && r >= 1 && r <= 8 && (o % BAUD) == BAUD / 2)
                            rx[o / BYTE_CYC][r-1] = tx_out;
                        rst_seen = reset_in;
                    end
                    if (!aborted) begin
                        check("sync_byte", rx[0], 8'hA5);
                        check("payload_byte", rx[1], f.b1);
                        check("checksum_byte", rx[2], f.b2);
                        rx_last_pay = rx[1];
                        rx_last_chk = rx[2];
                        rx_frames++;
                    end
                end
                mon_active = 1'b0;
            end else begin
                check("idle_tx", tx_out, 1'b1);
                check("idle_busy", busy, 1'b0);
                check("idle_done", frame_done, 1'b0);
                rst_seen = reset_in;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock_in);
            #2;
        end
    endtask

    task automatic wait_busy(input string name);
        int i;
        i = 0;
        while (busy !== 1'b1 && i < 400) begin
            tick(1);
            i++;
        end
        check(name, busy, 1'b1);
    endtask

    initial begin : driver
        int f0;
        int i;
        reset_in = 1'b1;
        enable   = 1'b1;
        tick(3);
        reset_in = 1'b0;
        tick(130);
        check("t1_payload", rx_last_pay, 8'h00);
        check("t1_checksum", rx_last_chk, 8'hA5);
        check("t1_frames", rx_frames, 1);

        player_id = 2'd2;
        up        = 1'b1;
        tick(130);
        check("t2_payload", rx_last_pay, 8'h84);
        check("t2_checksum", rx_last_chk, 8'h21);

        chop = 1'b1;
        wait_busy("t3_busy");
        tick(64);
        left = 1'b1;
        f0 = rx_frames;
        tick(260);
        check("t3_frames", rx_frames - f0, 2);
        check("t3_payload", rx_last_pay, 8'h95);

        f0 = rx_frames;
        tick(700);
        check("t4_heartbeats", rx_frames - f0, 2);
        check("t4_payload", rx_last_pay, 8'h95);

        wait_busy("t5_busy");
        tick(20);
        enable = 1'b0;
        f0 = rx_frames;
        tick(400);
        check("t5_frames", rx_frames - f0, 1);
        enable = 1'b1;
        tick(1);
        check("t5_resume", busy, 1'b1);

        for (int n = 0; n < 30; n++) begin
            tick($urandom_range(1, 300));
            {player_id, carry, chop, down, up, right, left} = 8'($urandom);
            if ($urandom_range(0, 5) == 0) enable = ~enable;
        end
        enable = 1'b1;
        tick(50);

        wait_busy("t6_busy");
        tick(15);
        reset_in = 1'b1;
        tick(1);
        check("t6_tx", tx_out, 1'b1);
        check("t6_busy_low", busy, 1'b0);
        reset_in = 1'b0;
        f0 = rx_frames;
        tick(140);
        check("t6_forced_frame", rx_frames - f0, 1);

        enable = 1'b0;
        i = 0;
        while ((busy || mon_active || exp_q.size() != 0) && i < 1000) begin
            tick(1);
            i++;
        end
        check("drain", {busy, mon_active, exp_q.size() == 0}, 3'b001);
        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
